divider_restoring: RTL
======================

DIVIDER_RESTORING -- requirements
Module: DIVIDER_RESTORING

Interface
REQ-001 Parameter: N, default 4, operand width in bits (N >= 2).
REQ-002 Port: clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 Port: rst  input  1  synchronous active-high reset.
REQ-004 Port: start  input  1  request to begin a division; sampled only in IDLE.
REQ-005 Port: A  input  N  unsigned dividend; captured on the edge that accepts start.
REQ-006 Port: B  input  N  unsigned divisor; captured on the edge that accepts start.
REQ-007 Port: Q  output  N  unsigned quotient.
REQ-008 Port: R  output  N  unsigned remainder.
REQ-009 Port: busy  output  1  high whenever state is not IDLE.
REQ-010 Port: done  output  1  one-cycle pulse; Q, R and DIV_ZERO are valid in that cycle.
REQ-011 Port: DIV_ZERO  output  1  high with done when the captured B was 0.

Function
REQ-012 The block SHALL be a state machine with states IDLE, RUN, DONE.
REQ-013 IDLE with start=1 and B!=0 SHALL capture A and B, clear the partial remainder, load iteration count N, and go to RUN.
REQ-014 IDLE with start=1 and B=0 SHALL go directly to DONE with Q=all ones, R=A, DIV_ZERO=1.
REQ-015 Each RUN cycle SHALL perform one restoring step, MSB first:
  - shift the partial remainder left and insert the next dividend bit;
  - trial-subtract B at N+1 bits;
  - if the result is non-negative, keep it and set the quotient bit to 1; otherwise restore and set the bit to 0;
  - decrement the count.
REQ-016 After the Nth RUN cycle the block SHALL go to DONE.
REQ-017 Normal-path latency: done SHALL assert exactly N+1 rising edges after the edge that accepted start. Divide-by-zero latency: exactly 1 edge.
REQ-018 DONE SHALL last one cycle, assert done, and then return to IDLE.
REQ-019 Q, R and DIV_ZERO SHALL update only on entry to DONE, and SHALL hold their values until the next entry to DONE or reset.
REQ-020 start SHALL be ignored in RUN and DONE; no queuing. A start in the DONE cycle is lost.
REQ-021 A and B SHALL be don't-care after capture; input changes during RUN SHALL NOT affect the result.
REQ-022 Results SHALL satisfy A = Q*B + R with R < B for every B != 0, including A=0 and A < B (Q=0, R=A).
REQ-023 All arithmetic SHALL be unsigned. The trial difference SHALL be N+1 bits wide, with bit N as the borrow/sign.

Reset
REQ-024 rst=1 at a rising edge SHALL force state IDLE and set Q=0, R=0, busy=0, done=0, DIV_ZERO=0, count=0.
REQ-025 rst SHALL take priority over start and over any in-flight operation. An operation aborted mid-RUN SHALL produce no done pulse.
REQ-026 The first start SHALL be accepted on the first edge after rst deasserts.

Structure
REQ-027 The state enum (IDLE, RUN, DONE) SHALL live in the shared package ALU_PKG.
REQ-028 The trial subtraction SHALL be implemented with one instance of the existing ADDER_FULL sub-module:
  - width N+1;
  - inputs: shifted remainder and the bitwise-inverted zero-extended divisor;
  - C_IN=1.
REQ-029 No other sub-modules SHALL be used. Count width SHALL be $clog2(N+1).

Verification
REQ-030 N=4, A=13, B=3, start pulse -> done exactly 5 edges later; Q=4, R=1, DIV_ZERO=0; busy high for 5 cycles.
REQ-031 N=4, A=5, B=0 -> done on the next edge; Q=15, R=5, DIV_ZERO=1.
REQ-032 N=4, A=2, B=7 -> Q=0, R=2. Then A=15, B=1 -> Q=15, R=0. Then A=15, B=15 -> Q=1, R=0.
REQ-033 N=4, A=12, B=5, start; toggle A/B and pulse start during RUN -> Q=2, R=2; exactly one done pulse.
REQ-034 N=4, A=9, B=2, start; assert rst on the 2nd RUN cycle -> Q=0, R=0, busy=0, and no done pulse. A new start (A=9, B=2) on the first edge after release -> Q=4, R=1.
REQ-035 N=4: exhaustive sweep of all 256 (A, B) pairs with back-to-back starts issued the cycle after each done -> every result matches REQ-022 or REQ-014.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the arithmetic blocks: controller state encoding.
package alu_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/adder_full.sv
// W-bit ripple adder with carry-in; used by the divider for the trial subtraction.
module adder_full #(
   parameter int unsigned W = 5
) (
   input  logic [W-1:0] A,
   input  logic [W-1:0] B,
   input  logic         C_IN,
   output logic [W-1:0] S
);

   // Sum wraps at W bits; the caller reads the top bit as the sign.
   always_comb begin
      S = A + B + W'(C_IN);
   end

endmodule

// File: rtl/divider_restoring.sv
// Unsigned restoring divider: one quotient bit per cycle, MSB first.
// Divide by zero short-cuts to DONE with Q = all ones, R = A.
module divider_restoring #(
   parameter int unsigned N = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [N-1:0] A,
   input  logic [N-1:0] B,
   output logic [N-1:0] Q,
   output logic [N-1:0] R,
   output logic         busy,
   output logic         done,
   output logic         DIV_ZERO
);

   import alu_pkg::*;

   localparam int unsigned CW = $clog2(N + 1);

   state_t        state;
   state_t        state_next;
   logic [CW-1:0] count;
   logic [N-1:0]  rem;       // partial remainder
   logic [N-1:0]  dvd;       // dividend bits shift out, quotient bits shift in
   logic [N-1:0]  dvs;       // captured divisor
   logic [N:0]    shifted;
   logic [N:0]    trial;
   logic          q_bit;
   logic [N-1:0]  rem_next;
   logic          last_step;

   // Trial subtraction: shifted - dvs as shifted + ~dvs + 1 at N+1 bits.
   adder_full #(
      .W (N + 1)
   ) u_sub (
      .A    (shifted),
      .B    (~{1'b0, dvs}),
      .C_IN (1'b1),
      .S    (trial)
   );

   // One restoring step: bit N of the difference is the borrow.
   always_comb begin
      shifted   = {rem, dvd[N-1]};
      q_bit     = ~trial[N];
      rem_next  = q_bit ? trial[N-1:0] : shifted[N-1:0];
      last_step = (count == CW'(1));
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (start) begin
               state_next = (B == '0) ? DONE : RUN;
            end
         end
         RUN: begin
            if (last_step) begin
               state_next = DONE;
            end
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Datapath and result registers; results only change on entry to DONE.
   always_ff @(posedge clk) begin
      if (rst) begin
         count    <= '0;
         rem      <= '0;
         dvd      <= '0;
         dvs      <= '0;
         Q        <= '0;
         R        <= '0;
         DIV_ZERO <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  if (B == '0) begin
                     Q        <= '1;
                     R        <= A;
                     DIV_ZERO <= 1'b1;
                  end else begin
                     dvd   <= A;
                     dvs   <= B;
                     rem   <= '0;
                     count <= CW'(N);
                  end
               end
            end
            RUN: begin
               rem   <= rem_next;
               dvd   <= {dvd[N-2:0], q_bit};
               count <= count - CW'(1);
               if (last_step) begin
                  Q        <= {dvd[N-2:0], q_bit};
                  R        <= rem_next;
                  DIV_ZERO <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   // Status outputs decoded from state.
   always_comb begin
      busy = (state != IDLE);
      done = (state == DONE);
   end

endmodule
